// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two combinational read ports with write bypass, two write
// ports, a per-register pending scoreboard and a post-reset init sequencer.
module reg_file_mp #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     AW       = 5,
  parameter int unsigned     SP_IDX   = 2,
  parameter logic [XLEN-1:0] SP_INIT  = XLEN'(128),
  parameter bit              ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_pending,
  output logic            rs2_pending,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   wd0,
  input  logic [AW-1:0]   wd1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  output logic            init_busy
);

  localparam int unsigned NREG = 2 ** AW;

  typedef enum logic {StInit, StRun} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic            run, wv0, wv1;
  logic [AW-1:0]   rs_idx [2];
  logic [XLEN-1:0] rdata [2];
  logic            rpend [2];

  assign run       = (state_q == StRun);
  assign init_busy = ~run;
  // A valid write is one that actually lands in the array.
  assign wv0 = run && we0 && !(ZERO_REG && (wd0 == '0));
  assign wv1 = run && we1 && !(ZERO_REG && (wd1 == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else if (state_q == StInit) begin
      cnt_q <= cnt_q + AW'(1);
      if (cnt_q == AW'(NREG - 1)) state_q <= StRun;
    end
  end

  // No reset on the array so it can map to RAM; the sequencer provides the initial contents.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_q] <= (cnt_q == AW'(SP_IDX)) ? SP_INIT : '0;
    end else begin
      if (wv0) mem[wd0] <= wdata0;
      if (wv1) mem[wd1] <= wdata1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (wv0 && (wd0 == AW'(i))) pending_d[i] = 1'b0;
      if (wv1 && (wd1 == AW'(i))) pending_d[i] = 1'b0;
      // A new producer supersedes a writeback to the same register.
      if (run && issue_we && (issue_rd == AW'(i)) && !(ZERO_REG && (i == 0))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign rs_idx[0] = rs1;
  assign rs_idx[1] = rs2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rpend[p] = 1'b0;
      if (run) begin
        if (ZERO_REG && (rs_idx[p] == '0))   rdata[p] = '0;
        else if (we1 && (wd1 == rs_idx[p])) rdata[p] = wdata1;
        else if (we0 && (wd0 == rs_idx[p])) rdata[p] = wdata0;
        else                                 rdata[p] = mem[rs_idx[p]];
        rpend[p] = pending_q[rs_idx[p]] &&
                   !((wv0 && (wd0 == rs_idx[p])) || (wv1 && (wd1 == rs_idx[p])));
      end
    end
  end

  assign rs1_data    = rdata[0];
  assign rs2_data    = rdata[1];
  assign rs1_pending = rpend[0];
  assign rs2_pending = rpend[1];

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic against an
// array-based reference model; a second 64-bit/8-entry instance covers the parameter sweep.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  rs1, rs2, wd0, wd1, issue_rd;
  logic [31:0] rs1_data, rs2_data, wdata0, wdata1;
  logic        rs1_pending, rs2_pending, we0, we1, issue_we, init_busy;

  logic        b_rst_n;
  logic [2:0]  b_rs1, b_rs2, b_wd0, b_wd1, b_issue_rd;
  logic [63:0] b_rs1_data, b_rs2_data, b_wdata0, b_wdata1;
  logic        b_rs1_pending, b_rs2_pending, b_we0, b_we1, b_issue_we, b_init_busy;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending), .we0(we0), .we1(we1), .wd0(wd0),
    .wd1(wd1), .wdata0(wdata0), .wdata1(wdata1), .issue_we(issue_we), .issue_rd(issue_rd),
    .init_busy(init_busy)
  );

  reg_file_mp #(.XLEN(64), .AW(3), .SP_IDX(2), .SP_INIT(64'h1000), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .rs1(b_rs1), .rs2(b_rs2), .rs1_data(b_rs1_data),
    .rs2_data(b_rs2_data), .rs1_pending(b_rs1_pending), .rs2_pending(b_rs2_pending),
    .we0(b_we0), .we1(b_we1), .wd0(b_wd0), .wd1(b_wd1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .issue_we(b_issue_we), .issue_rd(b_issue_rd), .init_busy(b_init_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl [32];
  bit          pend [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mdl[i]  = (i == 2) ? 32'd128 : 32'd0;
      pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; we0 = 1'b0; we1 = 1'b0; wd0 = '0; wd1 = '0;
    wdata0 = '0; wdata1 = '0; issue_we = 1'b0; issue_rd = '0;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (we1 && wd1 == r) return wdata1;
    if (we0 && wd0 == r) return wdata0;
    return mdl[r];
  endfunction

  function automatic logic exp_pend(input logic [4:0] r);
    logic wb;
    wb = (we0 && wd0 != 5'd0 && wd0 == r) || (we1 && wd1 != 5'd0 && wd1 == r);
    return pend[r] && !wb;
  endfunction

  // Called shortly after a negedge with inputs applied; compares against the model.
  task automatic apply();
    #1;
    check("busy_run", {63'd0, init_busy}, 64'd0);
    check("rs1_data", {32'd0, rs1_data}, {32'd0, exp_data(rs1)});
    check("rs2_data", {32'd0, rs2_data}, {32'd0, exp_data(rs2)});
    check("rs1_pend", {63'd0, rs1_pending}, {63'd0, exp_pend(rs1)});
    check("rs2_pend", {63'd0, rs2_pending}, {63'd0, exp_pend(rs2)});
  endtask

  // Commits the current inputs to the model, then advances through the edge.
  task automatic tick();
    if (we0 && wd0 != 5'd0) mdl[wd0] = wdata0;
    if (we1 && wd1 != 5'd0) mdl[wd1] = wdata1;
    if (we0 && wd0 != 5'd0) pend[wd0] = 1'b0;
    if (we1 && wd1 != 5'd0) pend[wd1] = 1'b0;
    if (issue_we && issue_rd != 5'd0) pend[issue_rd] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; b_rst_n = 1'b0;
    idle();
    b_rs1 = '0; b_rs2 = '0; b_we0 = 1'b0; b_we1 = 1'b0; b_wd0 = '0; b_wd1 = '0;
    b_wdata0 = '0; b_wdata1 = '0; b_issue_we = 1'b0; b_issue_rd = '0;
    rs1 = 5'd2;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {63'd0, init_busy}, 64'd1);
    check("rst_data", {32'd0, rs1_data}, 64'd0);
    check("rst_pend", {63'd0, rs1_pending}, 64'd0);
    @(negedge clk);

    // Reset then idle: count init cycles.
    rst_n = 1'b1;
    #1;
    cnt = 0;
    while (init_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check("init_len", 64'(cnt), 64'd32);
    @(negedge clk);
    model_reset();

    idle(); rs1 = 5'd2; rs2 = 5'd5;
    apply();
    check("sp_seed", {32'd0, rs1_data}, 64'd128);
    check("r5_zero", {32'd0, rs2_data}, 64'd0);
    rs1 = 5'd31;
    #1;
    check("r31_zero", {32'd0, rs1_data}, 64'd0);
    tick();

    // Single write with same-cycle bypass, then no-forward when we0 is low.
    idle(); we0 = 1'b1; wd0 = 5'd7; wdata0 = 32'hDEADBEEF; rs1 = 5'd7;
    apply(); check("byp0_same", {32'd0, rs1_data}, 64'hDEADBEEF); tick();
    idle(); rs1 = 5'd7;
    apply(); check("byp0_next", {32'd0, rs1_data}, 64'hDEADBEEF); tick();
    idle(); wd0 = 5'd7; wdata0 = 32'h12345678; rs1 = 5'd7;
    apply(); check("no_fwd", {32'd0, rs1_data}, 64'hDEADBEEF); tick();

    // Dual write, same index: port 1 wins.
    idle(); we0 = 1'b1; we1 = 1'b1; wd0 = 5'd9; wd1 = 5'd9; wdata0 = 32'h11; wdata1 = 32'h22;
    rs1 = 5'd9;
    apply(); check("dual_same", {32'd0, rs1_data}, 64'h22); tick();
    idle(); rs1 = 5'd9;
    apply(); check("dual_next", {32'd0, rs1_data}, 64'h22); tick();

    // Index 0 is hardwired.
    idle(); we0 = 1'b1; we1 = 1'b1; wdata0 = 32'hFF; wdata1 = 32'hEE;
    issue_we = 1'b1; issue_rd = 5'd0;
    apply(); check("zero_same", {32'd0, rs1_data}, 64'd0); tick();
    idle();
    apply(); check("zero_next", {32'd0, rs1_data}, 64'd0);
    check("zero_pend", {63'd0, rs1_pending}, 64'd0); tick();

    // Scoreboard.
    idle(); issue_we = 1'b1; issue_rd = 5'd4; rs2 = 5'd4;
    apply(); check("sb_before", {63'd0, rs2_pending}, 64'd0); tick();
    idle(); rs2 = 5'd4;
    apply(); check("sb_set", {63'd0, rs2_pending}, 64'd1); tick();
    idle(); we1 = 1'b1; wd1 = 5'd4; wdata1 = 32'hA5A5_0004; rs2 = 5'd4;
    apply(); check("sb_wb_pend", {63'd0, rs2_pending}, 64'd0);
    check("sb_wb_data", {32'd0, rs2_data}, 64'hA5A5_0004); tick();
    idle(); rs2 = 5'd4;
    apply(); check("sb_clr", {63'd0, rs2_pending}, 64'd0); tick();
    idle(); issue_we = 1'b1; issue_rd = 5'd4; we1 = 1'b1; wd1 = 5'd4; wdata1 = 32'h44; rs2 = 5'd4;
    apply(); tick();
    idle(); rs2 = 5'd4;
    apply(); check("sb_set_wins", {63'd0, rs2_pending}, 64'd1); tick();

    // Randomized traffic.
    for (int it = 0; it < 1500; it++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 1) == 0);
      rs1      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs2      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wd0      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wd1      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      issue_rd = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      we0      = ($urandom_range(0, 2) == 0);
      we1      = ($urandom_range(0, 2) == 0);
      issue_we = ($urandom_range(0, 2) == 0);
      wdata0   = $urandom;
      wdata1   = $urandom;
      apply();
      tick();
    end

    // Reset during INIT, with a write and an issue held while re-initialising.
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, init_busy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    we0 = 1'b1; wd0 = 5'd3; wdata0 = 32'h55; issue_we = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
    #1;
    check("init_rd0", {32'd0, rs1_data}, 64'd0);
    cnt = 0;
    while (init_busy && cnt < 100) begin
      cnt++;
      if (cnt == 20) idle();
      @(negedge clk);
      #1;
    end
    check("reinit_len", 64'(cnt), 64'd32);
    @(negedge clk);
    model_reset();
    idle(); rs1 = 5'd3; rs2 = 5'd2;
    apply(); check("init_wr_ign", {32'd0, rs1_data}, 64'd0); tick();

    // 64-bit, 8-entry instance.
    b_rst_n = 1'b1;
    #1;
    cnt = 0;
    while (b_init_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check("b_init_len", 64'(cnt), 64'd8);
    b_rs1 = 3'd2; b_rs2 = 3'd7;
    #1;
    check("b_sp_seed", b_rs1_data, 64'h1000);
    check("b_r7_zero", b_rs2_data, 64'd0);
    b_we0 = 1'b1; b_wd0 = 3'd5; b_wdata0 = 64'hCAFEBABE_12345678; b_rs2 = 3'd5;
    #1;
    check("b_byp", b_rs2_data, 64'hCAFEBABE_12345678);
    @(posedge clk);
    @(negedge clk);
    b_we0 = 1'b0;
    #1;
    check("b_rt", b_rs2_data, 64'hCAFEBABE_12345678);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
